// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, byte-lane steering and load extension.
// Optional WAIT watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        fun3,
  input  logic [31:0]       ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic              mem_load,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_reg, state_next;
  logic        err_reg, err_next;
  logic        is_store_reg;
  logic [2:0]  fun3_reg;
  logic [1:0]  off_reg;
  logic [31:0] wb_data_reg;
  logic [3:0]  mask_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0] wdata_reg;

  logic [1:0]  offset;
  logic        offered, fun3_ok, misalign, accept, illegal;
  logic [3:0]  mask_new;
  logic [31:0] wdata_new;
  logic [15:0] lane;
  logic [31:0] load_ext;
  logic        unused_bits;

  assign unused_bits = &{1'b0, ex_addr[31:ADDR_W+2], TMO_CYC[0]};

  assign offset   = ex_addr[1:0];
  assign offered  = (state_reg == IDLE) && ex_valid && (ex_load || ex_store);
  assign fun3_ok  = ex_store ? (fun3 inside {3'b000, 3'b001, 3'b010})
                             : (fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110});
  assign misalign = ((fun3[1:0] == 2'b01) && (offset == 2'b11)) ||
                    ((fun3[1:0] == 2'b10) && (offset != 2'b00));
  assign accept   = offered && (ex_load ^ ex_store) && fun3_ok && !misalign;
  assign illegal  = offered && !accept;

  // Store lane steering; sb replicates the byte so every lane carries it.
  always_comb begin
    mask_new  = 4'b1111;
    wdata_new = ex_wdata;
    case (fun3[1:0])
      2'b00: begin
        mask_new  = 4'b0001 << offset;
        wdata_new = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        mask_new  = 4'b0011 << offset;
        wdata_new = {16'h0000, ex_wdata[15:0]} << {offset, 3'b000};
      end
      default: ;
    endcase
  end

  assign lane = 16'(mem_rdata >> {off_reg, 3'b000});

  always_comb begin
    load_ext = mem_rdata;
    case (fun3_reg)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h000000, lane[7:0]};
      3'b101:  load_ext = {16'h0000, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt_reg;
  logic             tmo_hit;

  assign tmo_hit = (tmo_cnt_reg == CNT_W'(TMO_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 tmo_cnt_reg <= '0;
    else if (state_reg == WAIT) tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
    else                      tmo_cnt_reg <= '0;
  end
`else
  logic tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept)  state_next = ISSUE;
        if (illegal) err_next   = 1'b1;
      end
      ISSUE: state_next = is_store_reg ? DONE : WAIT;
      WAIT: begin
        if (mem_valid) begin
          state_next = DONE;
        end else if (tmo_hit) begin
          state_next = IDLE;
          err_next   = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      err_reg      <= 1'b0;
      is_store_reg <= 1'b0;
      fun3_reg     <= 3'b000;
      off_reg      <= 2'b00;
      mask_reg     <= 4'b0000;
      addr_reg     <= '0;
      wdata_reg    <= 32'h0;
      wb_data_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (accept) begin
        is_store_reg <= ex_store;
        fun3_reg     <= fun3;
        off_reg      <= offset;
        mask_reg     <= mask_new;
        addr_reg     <= ex_addr[ADDR_W+1:2];
        wdata_reg    <= wdata_new;
      end
      if (state_reg == WAIT && mem_valid) wb_data_reg <= load_ext;
    end
  end

  assign mem_request = (state_reg == ISSUE);
  assign mem_we_re   = (state_reg == ISSUE) && is_store_reg;
  assign mem_load    = (state_reg == ISSUE) && !is_store_reg;
  assign mem_mask    = mask_reg;
  assign mem_address = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign busy        = accept || (state_reg == ISSUE) || (state_reg == WAIT);
  assign wb_valid    = (state_reg == DONE);
  assign wb_data     = wb_data_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: store steering, load extension, faults, reset and WAIT behaviour.
module tb_lsu_ctrl;
  localparam int ADDR_W  = 8;
  localparam int TMO_CYC = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ex_valid = 1'b0, ex_load = 1'b0, ex_store = 1'b0;
  logic [2:0]        fun3 = 3'b000;
  logic [31:0]       ex_addr = 32'h0, ex_wdata = 32'h0;
  logic              mem_request, mem_we_re, mem_load;
  logic [3:0]        mem_mask;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = 32'h0;
  logic              mem_valid = 1'b0;
  logic              busy, wb_valid, err;
  logic [31:0]       wb_data;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(ADDR_W), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .fun3(fun3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_load(mem_load),
    .mem_mask(mem_mask), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid),
    .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " request"}, {31'h0, mem_request}, 32'h0);
    check({tag, " we_re"},   {31'h0, mem_we_re},   32'h0);
    check({tag, " load"},    {31'h0, mem_load},    32'h0);
    check({tag, " wb_valid"},{31'h0, wb_valid},    32'h0);
    check({tag, " busy"},    {31'h0, busy},        32'h0);
  endtask

  task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_mask,
                          input logic [ADDR_W-1:0] exp_addr, input logic [31:0] cmp,
                          input logic [31:0] exp_wd);
    ex_valid = 1'b1; ex_store = 1'b1; ex_load = 1'b0; fun3 = f3; ex_addr = addr; ex_wdata = wd;
    #1 check({tag, " busy@accept"}, {31'h0, busy}, 32'h1);
    step();
    ex_valid = 1'b0; ex_store = 1'b0;
    check({tag, " request"}, {31'h0, mem_request}, 32'h1);
    check({tag, " we_re"},   {31'h0, mem_we_re},   32'h1);
    check({tag, " load"},    {31'h0, mem_load},    32'h0);
    check({tag, " mask"},    {28'h0, mem_mask},    {28'h0, exp_mask});
    check({tag, " address"}, 32'(mem_address),     32'(exp_addr));
    check({tag, " wdata"},   mem_wdata & cmp,      exp_wd);
    step();
    check({tag, " wb_valid"}, {31'h0, wb_valid},   32'h1);
    check({tag, " busy@done"},{31'h0, busy},       32'h0);
    step();
    check({tag, " wb_valid end"}, {31'h0, wb_valid}, 32'h0);
  endtask

  task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rd, input logic [31:0] exp);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; fun3 = f3; ex_addr = addr;
    #1 check({tag, " busy@accept"}, {31'h0, busy}, 32'h1);
    step();
    ex_valid = 1'b0; ex_load = 1'b0;
    check({tag, " request"}, {31'h0, mem_request}, 32'h1);
    check({tag, " load"},    {31'h0, mem_load},    32'h1);
    check({tag, " we_re"},   {31'h0, mem_we_re},   32'h0);
    check({tag, " address"}, 32'(mem_address),     32'(addr[ADDR_W+1:2]));
    step();
    mem_valid = 1'b1; mem_rdata = rd;
    check({tag, " busy@wait"}, {31'h0, busy}, 32'h1);
    step();
    mem_valid = 1'b0; mem_rdata = 32'h0;
    check({tag, " wb_valid"}, {31'h0, wb_valid}, 32'h1);
    check({tag, " wb_data"},  wb_data, exp);
    step();
    check({tag, " wb_valid end"}, {31'h0, wb_valid}, 32'h0);
    check({tag, " wb_data hold"}, wb_data, exp);
  endtask

  task automatic illegal_op(input string tag, input logic ld, input logic st,
                            input logic [2:0] f3, input logic [31:0] addr);
    ex_valid = 1'b1; ex_load = ld; ex_store = st; fun3 = f3; ex_addr = addr;
    #1 check({tag, " busy"}, {31'h0, busy}, 32'h0);
    step();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    check({tag, " err"},     {31'h0, err},         32'h1);
    check({tag, " request"}, {31'h0, mem_request}, 32'h0);
    step();
    check({tag, " err end"}, {31'h0, err}, 32'h0);
    check_quiet({tag, " after"});
  endtask

  initial begin
    logic err_seen;
    #3;
    check("rst mask",    {28'h0, mem_mask}, 32'h0);
    check("rst address", 32'(mem_address),  32'h0);
    check("rst wdata",   mem_wdata,         32'h0);
    check("rst wb_data", wb_data,           32'h0);
    check("rst err",     {31'h0, err},      32'h0);
    check_quiet("rst");
    @(negedge clk); rst = 1'b1;
    step();

    store_op("sb", 3'b000, 32'h0000_0006, 32'h0000_00A5, 4'b0100, 8'h01, 32'h00FF_0000, 32'h00A5_0000);
    store_op("sh", 3'b001, 32'h0000_0002, 32'h1234_BEEF, 4'b1100, 8'h00, 32'hFFFF_0000, 32'hBEEF_0000);
    store_op("sw", 3'b010, 32'hFFFF_F304, 32'hCAFE_F00D, 4'b1111, 8'hC1, 32'hFFFF_FFFF, 32'hCAFE_F00D);

    load_op("lb",     3'b000, 32'h0000_0007, 32'h80FF_0000, 32'hFFFF_FF80);
    load_op("lbu",    3'b100, 32'h0000_0007, 32'h80FF_0000, 32'h0000_0080);
    load_op("lh",     3'b001, 32'h0000_0002, 32'h8001_1234, 32'hFFFF_8001);
    load_op("lhu",    3'b101, 32'h0000_0002, 32'h8001_1234, 32'h0000_8001);
    load_op("lh off1",3'b001, 32'h0000_0001, 32'h00AB_CD00, 32'hFFFF_ABCD);
    load_op("lbu off1",3'b100,32'h0000_0001, 32'h0000_7F00, 32'h0000_007F);
    load_op("lw",     3'b010, 32'h0000_0014, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    illegal_op("sw misalign", 1'b0, 1'b1, 3'b010, 32'h0000_0002);
    illegal_op("ld+st",       1'b1, 1'b1, 3'b000, 32'h0000_0000);
    illegal_op("st fun3 100", 1'b0, 1'b1, 3'b100, 32'h0000_0000);
    illegal_op("lh off3",     1'b1, 1'b0, 3'b001, 32'h0000_0003);

    // mem_valid outside WAIT must not disturb anything
    mem_valid = 1'b1; mem_rdata = 32'h1111_1111;
    step(); step();
    mem_valid = 1'b0;
    check("stray valid wb_valid", {31'h0, wb_valid}, 32'h0);
    check("stray valid wb_data",  wb_data, 32'hDEAD_BEEF);

    // reset asserted while waiting for read data
    ex_valid = 1'b1; ex_load = 1'b1; fun3 = 3'b010; ex_addr = 32'h0000_0008;
    step();
    ex_valid = 1'b0; ex_load = 1'b0;
    step();
    check("pre-rst busy", {31'h0, busy}, 32'h1);
    rst = 1'b0;
    #1;
    check("rst wait mask",    {28'h0, mem_mask}, 32'h0);
    check("rst wait address", 32'(mem_address),  32'h0);
    check("rst wait wb_data", wb_data,           32'h0);
    check("rst wait err",     {31'h0, err},      32'h0);
    check_quiet("rst wait");
    #2 rst = 1'b1;
    mem_valid = 1'b1; mem_rdata = 32'h2222_2222;
    step();
    mem_valid = 1'b0;
    step();
    check_quiet("post-rst");
    load_op("lw post-rst", 3'b010, 32'h0000_000C, 32'h0BAD_F00D, 32'h0BAD_F00D);

`ifdef LSU_TIMEOUT_EN
    ex_valid = 1'b1; ex_load = 1'b1; fun3 = 3'b010; ex_addr = 32'h0000_0010;
    step();
    ex_valid = 1'b0; ex_load = 1'b0;
    step();
    err_seen = 1'b0;
    for (int k = 1; k < TMO_CYC; k++) begin
      step();
      err_seen = err_seen | err;
    end
    check("tmo early err", {31'h0, err_seen}, 32'h0);
    check("tmo busy",      {31'h0, busy},     32'h1);
    step();
    check("tmo err",      {31'h0, err},      32'h1);
    check("tmo wb_valid", {31'h0, wb_valid}, 32'h0);
    check("tmo busy end", {31'h0, busy},     32'h0);
    step();
    check("tmo err end",  {31'h0, err},      32'h0);
    check_quiet("tmo idle");
`else
    ex_valid = 1'b1; ex_load = 1'b1; fun3 = 3'b000; ex_addr = 32'h0000_0010;
    step();
    ex_valid = 1'b0; ex_load = 1'b0;
    step();
    err_seen = 1'b0;
    for (int k = 0; k < 3 * TMO_CYC; k++) begin
      step();
      err_seen = err_seen | err | wb_valid;
    end
    check("nowdog no err",  {31'h0, err_seen}, 32'h0);
    check("nowdog busy",    {31'h0, busy},     32'h1);
    mem_valid = 1'b1; mem_rdata = 32'h0000_00F0;
    step();
    mem_valid = 1'b0;
    check("nowdog wb_valid", {31'h0, wb_valid}, 32'h1);
    check("nowdog wb_data",  wb_data, 32'hFFFF_FFF0);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
